// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Module   : common (package)
// Brief    : Scene primitive types and object-buffer constants.
// Revision : 1.0
// ============================================================================
package common;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } vertex_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  typedef struct packed {
    logic [3:0] kind;
    vertex_t    v0;
    vertex_t    v1;
    color_t     color;
  } object_t;

  localparam int OBJ_BUF_DEPTH_DEFAULT = 64;
  localparam int OBJ_PRELOAD_N         = 7;

  // Demo scene: {kind, v0.x, v0.y, v1.x, v1.y, rgb}
  localparam object_t OBJ_PRELOAD [OBJ_PRELOAD_N] = '{
    {4'd1, 12'd10,  12'd20,  12'd200, 12'd40,  24'hff0000},
    {4'd2, 12'd30,  12'd60,  12'd120, 12'd180, 24'h00ff00},
    {4'd3, 12'd300, 12'd10,  12'd340, 12'd90,  24'h0000ff},
    {4'd1, 12'd5,   12'd5,   12'd635, 12'd5,   24'hffffff},
    {4'd2, 12'd400, 12'd300, 12'd480, 12'd360, 24'h808000},
    {4'd3, 12'd100, 12'd400, 12'd160, 12'd470, 24'h008080},
    {4'd4, 12'd0,   12'd479, 12'd639, 12'd479, 24'h800080}
  };

endpackage
`default_nettype wire

// File: rtl/object_bank.sv
`default_nettype none
// ============================================================================
// Module   : object_bank
// Brief    : DEPTH-entry object memory, synchronous write, asynchronous read,
//            with an optional one-cycle load of the demo scene.
// Revision : 1.0
// ============================================================================
module object_bank
  import common::*;
#(
  parameter int DEPTH   = OBJ_BUF_DEPTH_DEFAULT,
  parameter bit PRELOAD = 1'b0,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          load,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  object_t       wr_data,
  input  logic [AW-1:0] rd_addr,
  output object_t       rd_data
);

  localparam int PW = $clog2(OBJ_PRELOAD_N);

  object_t r_mem [DEPTH];

  // The scene load wins over a coincident producer write.
  always_ff @(posedge clock) begin
    if (PRELOAD && load) begin
      for (int i = 0; i < OBJ_PRELOAD_N; i++) begin
        r_mem[AW'(i)] <= OBJ_PRELOAD[PW'(i)];
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/object_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : object_pingpong_buffer
// Brief    : Ping-pong object store; producer fills/commits the back bank,
//            rasteriser streams the front bank; swap only on rd_start.
//            Optional build macro: OBJECT_BUFFER_PRELOAD_EN (demo scene in
//            bank 0 after reset).
// Revision : 1.0
// ============================================================================
module object_pingpong_buffer
  import common::*;
#(
  parameter int DEPTH = OBJ_BUF_DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_valid,
  input  object_t       wr_data,
  output logic          wr_ready,
  input  logic          wr_commit,
  input  logic          rd_start,
  output logic          rd_valid,
  input  logic          rd_ready,
  output object_t       rd_data,
  output logic          rd_last,
  output logic [CW-1:0] front_count,
  output logic [CW-1:0] back_count,
  output logic          full,
  output logic          sealed
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] c_FILL   = 1'b0;
  localparam logic [0:0] c_SEALED = 1'b1;

`ifdef OBJECT_BUFFER_PRELOAD_EN
  localparam bit          c_PRELOAD        = 1'b1;
  localparam logic [CW-1:0] c_BANK0_RST_CNT = CW'(OBJ_PRELOAD_N);
`else
  localparam bit          c_PRELOAD        = 1'b0;
  localparam logic [CW-1:0] c_BANK0_RST_CNT = '0;
`endif

  logic [0:0]    r_state;
  logic          r_sel;
  logic [CW-1:0] r_count0;
  logic [CW-1:0] r_count1;
  logic [CW-1:0] r_rd_ptr;

  logic [CW-1:0] w_front_count;
  logic [CW-1:0] w_back_count;
  logic [CW-1:0] w_back_next;
  logic          w_full;
  logic          w_wr_ready;
  logic          w_wr;
  logic          w_commit;
  logic          w_swap;
  logic          w_rd_valid;
  logic          w_rd_fire;
  object_t       w_rd0;
  object_t       w_rd1;

  assign w_front_count = r_sel ? r_count1 : r_count0;
  assign w_back_count  = r_sel ? r_count0 : r_count1;
  assign w_full        = (w_back_count == CW'(DEPTH));
  assign w_wr_ready    = (r_state == c_FILL) && !w_full;
  assign w_wr          = wr_valid && w_wr_ready;
  assign w_back_next   = w_back_count + {{(CW-1){1'b0}}, w_wr};
  assign w_commit      = wr_commit && (r_state == c_FILL);
  // A commit landing together with rd_start is honoured in that same cycle.
  assign w_swap        = rd_start && ((r_state == c_SEALED) || w_commit);
  assign w_rd_valid    = (r_rd_ptr < w_front_count);
  assign w_rd_fire     = w_rd_valid && rd_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= c_FILL;
      r_sel    <= 1'b0;
      r_count0 <= c_BANK0_RST_CNT;
      r_count1 <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_swap) begin
        r_sel   <= ~r_sel;
        r_state <= c_FILL;
      end else if (w_commit) begin
        r_state <= c_SEALED;
      end

      // Back bank takes its post-write count; on a swap the old front empties.
      if (r_sel) begin
        r_count0 <= w_back_next;
        if (w_swap) r_count1 <= '0;
      end else begin
        r_count1 <= w_back_next;
        if (w_swap) r_count0 <= '0;
      end

      if (rd_start) begin
        r_rd_ptr <= '0;
      end else if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + CW'(1);
      end
    end
  end

  object_bank #(
    .DEPTH   (DEPTH),
    .PRELOAD (c_PRELOAD),
    .AW      (AW)
  ) u_bank0 (
    .clock   (clock),
    .load    (reset),
    .wr_en   (w_wr && r_sel),
    .wr_addr (w_back_count[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (r_rd_ptr[AW-1:0]),
    .rd_data (w_rd0)
  );

  object_bank #(
    .DEPTH   (DEPTH),
    .PRELOAD (1'b0),
    .AW      (AW)
  ) u_bank1 (
    .clock   (clock),
    .load    (1'b0),
    .wr_en   (w_wr && !r_sel),
    .wr_addr (w_back_count[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (r_rd_ptr[AW-1:0]),
    .rd_data (w_rd1)
  );

  assign wr_ready    = w_wr_ready;
  assign rd_valid    = w_rd_valid;
  assign rd_data     = r_sel ? w_rd1 : w_rd0;
  assign rd_last     = w_rd_valid && (r_rd_ptr == w_front_count - CW'(1));
  assign front_count = w_front_count;
  assign back_count  = w_back_count;
  assign full        = w_full;
  assign sealed      = (r_state == c_SEALED);

endmodule
`default_nettype wire
